// File: rtl/crypt_pkg.sv
// Shared definitions for the CRYPT block cipher: substitution constant, key schedule,
// byte packing helpers and the decryptor FSM state encoding.
package crypt_pkg;

  localparam logic [7:0] SUB_ADD = 8'h3B;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] b4;
  } word_bytes_t;

  // The key rotation is left by 8*(r mod 4), then every byte is XORed with the round index.
  function automatic logic [31:0] round_key(input logic [31:0] key, input logic [7:0] r);
    logic [31:0] rot;
    case (r[1:0])
      2'd0:    rot = key;
      2'd1:    rot = {key[23:0], key[31:24]};
      2'd2:    rot = {key[15:0], key[31:16]};
      default: rot = {key[7:0],  key[31:8]};
    endcase
    return rot ^ {4{r}};
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] b1, input logic [7:0] b2,
                                       input logic [7:0] b3, input logic [7:0] b4);
    return {b1, b2, b3, b4};
  endfunction

  function automatic word_bytes_t unpack(input logic [31:0] w);
    return word_bytes_t'(w);
  endfunction

endpackage

// File: rtl/crypt_inv_round.sv
// One inverse cipher round: rotate right a byte, per-byte subtract and nibble swap,
// then remove the round key. Purely combinational.
module crypt_inv_round
  import crypt_pkg::*;
(
  input  logic [31:0] s_i,
  input  logic [31:0] rk_i,
  output logic [31:0] s_o
);

  logic [31:0] rot;
  logic [31:0] swapped;

  assign rot = {s_i[7:0], s_i[31:8]};

  for (genvar i = 0; i < 4; i++) begin : g_byte
    logic [7:0] diff;
    // Byte lanes wrap independently; no borrow crosses into the neighbour lane.
    assign diff              = rot[8*i +: 8] - SUB_ADD;
    assign swapped[8*i +: 8] = {diff[3:0], diff[7:4]};
  end

  assign s_o = swapped ^ rk_i;

endmodule

// File: rtl/crypt_decrypt.sv
// Iterative CRYPT decryptor: loads a ciphertext word, applies one inverse round per
// clock from round ROUNDS-1 down to 0, then registers the plaintext and pulses DONE.
module crypt_decrypt
  import crypt_pkg::*;
#(
  parameter int          ROUNDS = 4,
  parameter logic [31:0] KEY    = 32'hA5C3_0F96
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [7:0] IN_1,
  input  logic [7:0] IN_2,
  input  logic [7:0] IN_3,
  input  logic [7:0] IN_4,
  output logic [7:0] OUT_1,
  output logic [7:0] OUT_2,
  output logic [7:0] OUT_3,
  output logic [7:0] OUT_4,
  output logic       BUSY,
  output logic       DONE
);

  localparam logic [3:0] RC_LAST = 4'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] s_q;
  logic [31:0] s_next;
  logic [31:0] out_q;
  logic [3:0]  rc_q;
  logic        done_q;
  logic        load;
  logic        last;
  word_bytes_t out_bytes;

  assign load = (state_q == ST_IDLE) && EN;
  assign last = (state_q == ST_RUN) && (rc_q == 4'd0);

  crypt_inv_round u_inv_round (
    .s_i  (s_q),
    .rk_i (round_key(KEY, {4'd0, rc_q})),
    .s_o  (s_next)
  );

  // NOTE: registers take <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (EN)   state_d = ST_RUN;
      ST_RUN:  if (last) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_q    <= '0;
      rc_q   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (load) begin
        s_q  <= pack(IN_1, IN_2, IN_3, IN_4);
        rc_q <= RC_LAST;
      end else if (state_q == ST_RUN) begin
        s_q <= s_next;
        if (rc_q != 4'd0) rc_q  <= rc_q - 4'd1;
        if (last)         out_q <= s_next;
      end
    end
  end

  always_comb begin
    out_bytes = unpack(out_q);
    BUSY      = (state_q == ST_RUN);
    DONE      = done_q;
    OUT_1     = out_bytes.b1;
    OUT_2     = out_bytes.b2;
    OUT_3     = out_bytes.b3;
    OUT_4     = out_bytes.b4;
  end

endmodule

// File: tb/tb_crypt_decrypt.sv
// Directed bench for crypt_decrypt: three parameterisations sharing clock, reset and
// ciphertext bus, each with its own start strobe.
module tb_crypt_decrypt;

  localparam logic [31:0] KEY_DEF = 32'hA5C3_0F96;
  localparam logic [31:0] KEY_16  = 32'h1234_5678;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        en  = '0;
  logic [31:0]       in_w = '0;
  logic [2:0][31:0]  outs;
  logic [2:0]        busy;
  logic [2:0]        done;

  int n_total = 0;
  int n_bad   = 0;

  always #20 clk = ~clk;

  crypt_decrypt #(.ROUNDS(1), .KEY(32'h0)) u_r1 (
    .CLK(clk), .RST(rst), .EN(en[0]),
    .IN_1(in_w[31:24]), .IN_2(in_w[23:16]), .IN_3(in_w[15:8]), .IN_4(in_w[7:0]),
    .OUT_1(outs[0][31:24]), .OUT_2(outs[0][23:16]), .OUT_3(outs[0][15:8]), .OUT_4(outs[0][7:0]),
    .BUSY(busy[0]), .DONE(done[0])
  );

  crypt_decrypt u_def (
    .CLK(clk), .RST(rst), .EN(en[1]),
    .IN_1(in_w[31:24]), .IN_2(in_w[23:16]), .IN_3(in_w[15:8]), .IN_4(in_w[7:0]),
    .OUT_1(outs[1][31:24]), .OUT_2(outs[1][23:16]), .OUT_3(outs[1][15:8]), .OUT_4(outs[1][7:0]),
    .BUSY(busy[1]), .DONE(done[1])
  );

  crypt_decrypt #(.ROUNDS(16), .KEY(KEY_16)) u_r16 (
    .CLK(clk), .RST(rst), .EN(en[2]),
    .IN_1(in_w[31:24]), .IN_2(in_w[23:16]), .IN_3(in_w[15:8]), .IN_4(in_w[7:0]),
    .OUT_1(outs[2][31:24]), .OUT_2(outs[2][23:16]), .OUT_3(outs[2][15:8]), .OUT_4(outs[2][7:0]),
    .BUSY(busy[2]), .DONE(done[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference encryptor, written lane by lane.
  function automatic logic [31:0] enc_model(input logic [31:0] pt, input logic [31:0] key,
                                            input int rounds);
    logic [31:0] s, rk, rot;
    logic [7:0]  b;
    int          sh;
    s = pt;
    for (int r = 0; r < rounds; r++) begin
      sh  = 8 * (r % 4);
      rot = (sh == 0) ? key : ((key << sh) | (key >> (32 - sh)));
      rk  = rot ^ {4{8'(r)}};
      s   = s ^ rk;
      for (int i = 0; i < 4; i++) begin
        b            = s[8*i +: 8];
        s[8*i +: 8]  = {b[3:0], b[7:4]} + 8'h3B;
      end
      s = {s[23:0], s[31:24]};
    end
    return s;
  endfunction

  // Start one operation on instance k and wait (bounded) for DONE.
  task automatic run_op(input int k, input logic [31:0] ct,
                        output logic [31:0] res, output int lat, output int busy_cyc);
    @(negedge clk);
    in_w  = ct;
    en[k] = 1'b1;
    @(posedge clk);
    #1;
    en[k]    = 1'b0;
    in_w     = ~ct;
    lat      = 0;
    busy_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy[k]) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
      if (done[k]) break;
    end
    res = outs[k];
    check("busy_low_at_done", 32'(busy[k]), 32'd0);
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'(done[k]), 32'd0);
    check("out_hold", outs[k], res);
  endtask

  logic [31:0] res, pt, ct;
  int          lat, bc, cnt, seen;

  initial begin
    #50;
    check("rst_out_r1",  outs[0], 32'h0);
    check("rst_out_def", outs[1], 32'h0);
    check("rst_busy",    32'(busy), 32'h0);
    check("rst_done",    32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single round, zero key
    run_op(0, 32'h18056DFE, res, lat, bc);
    check("r1_out",  res, 32'h3CDDAC23);
    check("r1_lat",  32'(lat), 32'd1);
    check("r1_busy", 32'(bc), 32'd1);

    // Byte wrap and zero-difference boundaries
    run_op(0, 32'h00000018, res, lat, bc);
    check("wrap_out", res, 32'hDD5C5C5C);
    run_op(0, 32'h3B3B3B3B, res, lat, bc);
    check("zero_out", res, 32'h00000000);
    run_op(0, 32'hFFFFFFFF, res, lat, bc);
    check("ff_out", res, 32'h4C4C4C4C);

    // Round trip, default parameters
    pt = 32'h3CDDAC23;
    ct = enc_model(pt, KEY_DEF, 4);
    run_op(1, ct, res, lat, bc);
    check("def_out",  res, pt);
    check("def_lat",  32'(lat), 32'd4);
    check("def_busy", 32'(bc), 32'd4);

    // Held EN: two back-to-back operations, input disturbed while busy
    @(negedge clk);
    in_w  = ct;
    en[1] = 1'b1;
    @(posedge clk);
    #1;
    in_w = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    in_w = ct;
    cnt  = 1;
    for (int i = 0; i < 40 && !done[1]; i++) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("held_lat1", 32'(cnt), 32'd4);
    check("held_out1", outs[1], pt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done[1]) break;
    end
    en[1] = 1'b0;
    check("held_spacing", 32'(cnt), 32'd5);
    check("held_out2", outs[1], pt);
    repeat (3) @(posedge clk);
    #1;
    check("held_stopped", 32'(busy[1]), 32'd0);

    // Reset mid-operation
    @(negedge clk);
    in_w  = enc_model(32'h01234567, KEY_DEF, 4);
    en[1] = 1'b1;
    @(posedge clk);
    #1;
    en[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out",  outs[1], 32'h0);
    check("abort_busy", 32'(busy[1]), 32'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done[1]) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pt  = 32'h89ABCDEF;
    run_op(1, enc_model(pt, KEY_DEF, 4), res, lat, bc);
    check("after_abort_out", res, pt);
    check("after_abort_lat", 32'(lat), 32'd4);

    // Random round trips on default and 16-round instances
    for (int n = 0; n < 12; n++) begin
      pt = $urandom;
      run_op(1, enc_model(pt, KEY_DEF, 4), res, lat, bc);
      check("rand_def", res, pt);
      pt = $urandom;
      run_op(2, enc_model(pt, KEY_16, 16), res, lat, bc);
      check("rand_r16", res, pt);
      check("rand_r16_lat", 32'(lat), 32'd16);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
